// File: rtl/tagged_response_demux_1_input_n_output.sv
// Routes tagged input beats into per-destination FIFOs; each port drains independently.
// Handshakes: a beat moves on a rising edge only when valid and ready are both high; ready never depends on valid.
module tagged_response_demux_1_input_n_output #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    localparam int ID_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enabled,
    input  logic                  in_valid,
    input  logic [ID_W-1:0]       in_dest,
    input  logic [0:WIDTH-1]      in_data,
    output logic                  in_ready,
    output logic [0:WIDTH-1]      out_data [0:NUM_PORTS-1],
    output logic [NUM_PORTS-1:0]  out_valid,
    input  logic [NUM_PORTS-1:0]  out_ready,
    output logic                  dest_error,
    output logic [31:0]           accepted_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_W:0]    PORT_LIMIT = (ID_W + 1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

    logic                 legal;
    logic                 dest_full;
    logic                 accept;
    logic [NUM_PORTS-1:0] full;

    assign legal = ({1'b0, in_dest} < PORT_LIMIT);

    always_comb begin
        dest_full = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if ((in_dest == ID_W'(i)) && full[i]) begin
                dest_full = 1'b1;
            end
        end
    end

    // Illegal destinations are always accepted so a bad tag can never stall the stream.
    assign in_ready = enabled & ~rst & (~legal | ~dest_full);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            accepted_count <= 32'd0;
            dest_error     <= 1'b0;
        end else if (accept) begin
            accepted_count <= accepted_count + 32'd1;
            if (!legal) begin
                dest_error <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [ID_W-1:0] PORT_ID = ID_W'(p);

        logic [0:WIDTH-1]  mem [DEPTH];
        logic [PTR_W-1:0]  rd_ptr;
        logic [PTR_W-1:0]  wr_ptr;
        logic [CNT_W-1:0]  count;
        logic              push;
        logic              pop;

        assign push = accept & legal & (in_dest == PORT_ID);
        assign pop  = out_valid[p] & out_ready[p];

        assign full[p]      = (count == FULL_CNT);
        assign out_valid[p] = enabled & (count != '0);
        assign out_data[p]  = (count != '0) ? mem[rd_ptr] : '0;

        // Storage needs no reset: the count gates everything read out of it.
        always_ff @(posedge clock) begin
            if (push) begin
                mem[wr_ptr] <= in_data;
            end
        end

        always_ff @(posedge clock or posedge rst) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_tagged_response_demux_1_input_n_output.sv
// Bench for the tagged response demux: queue-per-port reference model plus directed scenarios.
module tb_tagged_response_demux_1_input_n_output;
  localparam int NP = 4;
  localparam int W  = 8;
  localparam int D  = 4;

  // clock / reset block
  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  // main DUT: 4 ports
  logic            enabled;
  logic            in_valid;
  logic [1:0]      in_dest;
  logic [0:W-1]    in_data;
  logic            in_ready;
  logic [0:W-1]    out_data [0:NP-1];
  logic [NP-1:0]   out_valid;
  logic [NP-1:0]   out_ready;
  logic            dest_error;
  logic [31:0]     accepted_count;

  // second DUT: 3 ports, so destination 3 is illegal
  logic            b_valid;
  logic [1:0]      b_dest;
  logic [0:W-1]    b_data;
  logic            b_in_ready;
  logic [0:W-1]    b_out_data [0:2];
  logic [2:0]      b_out_valid;
  logic [2:0]      b_out_ready;
  logic            b_dest_error;
  logic [31:0]     b_accepted_count;

  tagged_response_demux_1_input_n_output #(.NUM_PORTS(NP), .WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .rst(rst), .enabled(enabled), .in_valid(in_valid), .in_dest(in_dest),
    .in_data(in_data), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .dest_error(dest_error), .accepted_count(accepted_count)
  );

  tagged_response_demux_1_input_n_output #(.NUM_PORTS(3), .WIDTH(W), .DEPTH(D)) dut_b (
    .clock(clock), .rst(rst), .enabled(enabled), .in_valid(b_valid), .in_dest(b_dest),
    .in_data(b_data), .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .dest_error(b_dest_error), .accepted_count(b_accepted_count)
  );

  // scoreboard: one expected queue per port
  logic [W-1:0] exp_q [NP][$];
  int exp_acc;
  int errors;
  int checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic          exp_rdy;
    logic [NP-1:0] exp_v;
    #1;
    exp_rdy = enabled && (exp_q[in_dest].size() < D);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int p = 0; p < NP; p++) begin
      exp_v[p] = enabled && (exp_q[p].size() != 0);
      chk($sformatf("out_data[%0d]", p), 32'(out_data[p]),
          (exp_q[p].size() != 0) ? 32'(exp_q[p][0]) : 32'd0);
    end
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("dest_error", 32'(dest_error), 32'd0);
    chk("accepted_count", accepted_count, 32'(exp_acc));
    @(posedge clock);
    for (int p = 0; p < NP; p++) begin
      if (exp_v[p] && out_ready[p]) void'(exp_q[p].pop_front());
    end
    if (in_valid && exp_rdy) begin
      exp_q[in_dest].push_back(in_data);
      exp_acc++;
    end
    @(negedge clock);
  endtask

  initial begin
    errors = 0; checks = 0; exp_acc = 0;
    rst = 1'b1; enabled = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0; out_ready = '0;
    b_valid = 1'b0; b_dest = '0; b_data = '0; b_out_ready = '0;

    // reset state
    #2;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    for (int p = 0; p < NP; p++) chk("rst out_data", 32'(out_data[p]), 32'd0);
    chk("rst dest_error", 32'(dest_error), 32'd0);
    chk("rst accepted_count", accepted_count, 32'd0);
    chk("rst b_in_ready", 32'(b_in_ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;

    // routing and one-cycle latency
    in_valid = 1'b1; in_dest = 2'd2; in_data = 8'hA1; out_ready = 4'hF;
    step();
    in_valid = 1'b0;
    chk("route out_valid", 32'(out_valid), 32'h4);
    chk("route out_data2", 32'(out_data[2]), 32'hA1);
    chk("route accepted", accepted_count, 32'd1);
    step();
    chk("route drained", 32'(out_valid), 32'h0);

    // illegal destination on the 3-port instance
    b_valid = 1'b1; b_dest = 2'd3; b_data = 8'h55;
    #1;
    chk("illegal b_in_ready", 32'(b_in_ready), 32'd1);
    step();
    b_valid = 1'b0;
    chk("illegal dest_error", 32'(b_dest_error), 32'd1);
    chk("illegal out_valid", 32'(b_out_valid), 32'd0);
    chk("illegal accepted", b_accepted_count, 32'd1);
    step();
    chk("illegal sticky", 32'(b_dest_error), 32'd1);

    // full port backpressure
    out_ready = 4'b1101; in_valid = 1'b1; in_dest = 2'd1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h10 + i);
      #1;
      chk("full in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    in_dest = 2'd0; in_data = 8'h20;
    #1;
    chk("other port ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain order", 32'(out_data[1]), 32'(8'h10 + i));
      step();
    end
    chk("drain empty", 32'(out_valid), 32'd0);

    // streaming with concurrent push and pop, pointers wrap
    in_valid = 1'b1; in_dest = 2'd3;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(8'h30 + i);
      step();
      chk("stream head", 32'(out_data[3]), 32'(8'h30 + i));
    end
    in_valid = 1'b0;
    repeat (2) step();

    // enable toggle retains contents
    out_ready = 4'h0; in_valid = 1'b1; in_dest = 2'd0;
    in_data = 8'h40; step();
    in_data = 8'h41; step();
    enabled = 1'b0; in_data = 8'h99; out_ready = 4'hF;
    repeat (3) step();
    in_valid = 1'b0; enabled = 1'b1;
    #1;
    chk("enable retained", 32'(out_data[0]), 32'h40);
    repeat (3) step();

    // randomized traffic
    repeat (400) begin
      enabled   = ($urandom_range(0, 9) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_dest   = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 4'($urandom_range(0, 15));
      step();
    end

    // reset mid-stream
    enabled = 1'b1; in_valid = 1'b0; out_ready = 4'hF;
    repeat (8) step();
    out_ready = 4'b1101; in_valid = 1'b1; in_dest = 2'd1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h50 + i);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_data1", 32'(out_data[1]), 32'd0);
    chk("midrst dest_error", 32'(b_dest_error), 32'd0);
    chk("midrst accepted", accepted_count, 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b0;
    for (int p = 0; p < NP; p++) exp_q[p].delete();
    exp_acc = 0;
    @(negedge clock);
    out_ready = 4'hF;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
